// File: rtl/lcd_rx.sv
// ---------------------------------------------------------------------------
// LcdRx -- serial LCD framebuffer receiver
//
// Captures a CPU-driven serial LCD stream (clock + data, MSB first) that is
// asynchronous to the FPGA clock. It assembles bytes and writes them into a
// framebuffer. A long low period on lcd_clk marks the gap between frames.
//
// Parameters
//    IDLE_CYCLES  fpga_clk cycles of lcd_clk low that mark a frame gap
//    FRAME_BYTES  bytes per frame (64x32 pixels, 1 bpp)
//
// Ports
//    fpga_clk    in   system clock, all logic on rising edge
//    rst_in      in   asynchronous active-low reset
//    lcd_clk     in   serial clock from cpu (asynchronous)
//    lcd_data    in   serial data from cpu, MSB first
//    fb_wr_en    out  one-cycle framebuffer write strobe
//    fb_wr_addr  out  byte address within frame (held between writes)
//    fb_wr_data  out  received byte (held between writes)
//    frame_done  out  one-cycle pulse alongside the last write of a frame
//    frame_err   out  sticky: gap seen mid-byte or frame short
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module lcd_rx #(
   parameter int IDLE_CYCLES = 64,
   parameter int FRAME_BYTES = 256
) (
   input  logic       fpga_clk,
   input  logic       rst_in,
   input  logic       lcd_clk,
   input  logic       lcd_data,
   output logic       fb_wr_en,
   output logic [7:0] fb_wr_addr,
   output logic [7:0] fb_wr_data,
   output logic       frame_done,
   output logic       frame_err
);

   localparam int             IW        = $clog2(IDLE_CYCLES + 1);
   localparam logic [IW-1:0]  IDLE_MAX  = IW'(IDLE_CYCLES);
   localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_CYCLES - 1);
   localparam logic [7:0]     LAST_BYTE = 8'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      GAP
   } state_t;

   state_t          state_q;
   state_t          state_d;

   logic            clk_meta;
   logic            clk_sync;
   logic            clk_prev;
   logic            data_meta;
   logic            data_sync;
   logic [IW-1:0]   idle_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift_reg;
   logic [7:0]      byte_idx;

   logic            rise;
   logic            idle_hit;
   logic            enter_gap;

   // A rising edge is a low-to-high transition of the synchronized clock
   // between consecutive cycles. The idle hit fires on the cycle the idle
   // counter is about to reach its limit. It therefore lines up with the
   // counter reaching IDLE_CYCLES. It can never coincide with an edge,
   // because an edge needs the synchronized clock high.
   assign rise      = clk_sync & ~clk_prev;
   assign idle_hit  = ~clk_sync && (idle_cnt == IDLE_LAST);
   assign enter_gap = (state_q == RECV) && (state_d == GAP);

   // Two-flop synchronizers for the asynchronous serial inputs, plus one
   // extra flop of history on the clock for edge detection.
   always_ff @(posedge fpga_clk or negedge rst_in) begin
      if (!rst_in) begin
         clk_meta  <= 1'b0;
         clk_sync  <= 1'b0;
         clk_prev  <= 1'b0;
         data_meta <= 1'b0;
         data_sync <= 1'b0;
      end else begin
         clk_meta  <= lcd_clk;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         data_meta <= lcd_data;
         data_sync <= data_meta;
      end
   end

   // Idle counter: counts synchronized-low cycles and clears on any high
   // cycle. It saturates so a long pause cannot wrap it around.
   always_ff @(posedge fpga_clk or negedge rst_in) begin
      if (!rst_in) begin
         idle_cnt <= '0;
      end else if (clk_sync) begin
         idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge fpga_clk or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state. Edges are handled by the datapath in every state.
   // Only the RECV-to-GAP transition has side effects of its own.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rise)     state_d = RECV;
         RECV:    if (idle_hit) state_d = GAP;
         GAP:     if (rise)     state_d = RECV;
         default:               state_d = IDLE;
      endcase
   end

   // Datapath: shift bits in on each edge. After the eighth bit, register
   // the write strobe for the following cycle. A frame gap restarts the
   // byte/bit position. A gap also flags an error if the gap cut a byte
   // or a frame short.
   always_ff @(posedge fpga_clk or negedge rst_in) begin
      if (!rst_in) begin
         bit_cnt    <= 3'd0;
         shift_reg  <= 8'd0;
         byte_idx   <= 8'd0;
         fb_wr_en   <= 1'b0;
         fb_wr_addr <= 8'd0;
         fb_wr_data <= 8'd0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         fb_wr_en   <= 1'b0;
         frame_done <= 1'b0;
         if (enter_gap) begin
            bit_cnt  <= 3'd0;
            byte_idx <= 8'd0;
            if ((bit_cnt != 3'd0) || (byte_idx != 8'd0)) begin
               frame_err <= 1'b1;
            end
         end else if (rise) begin
            shift_reg <= {shift_reg[6:0], data_sync};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               fb_wr_en   <= 1'b1;
               fb_wr_data <= {shift_reg[6:0], data_sync};
               fb_wr_addr <= byte_idx;
               if (byte_idx == LAST_BYTE) begin
                  byte_idx   <= 8'd0;
                  frame_done <= 1'b1;
               end else begin
                  byte_idx <= byte_idx + 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_rx.sv
// ---------------------------------------------------------------------------
// tb_lcd_rx -- directed self-checking bench for lcd_rx
//
// Drives the serial LCD interface with 4-cycle half periods. A monitor
// process records every framebuffer write and frame_done pulse. Each
// scenario then compares the recorded writes and the flags against
// hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lcd_rx;

   logic       fpga_clk = 1'b0;
   logic       rst_in   = 1'b0;
   logic       lcd_clk  = 1'b0;
   logic       lcd_data = 1'b0;
   logic       fb_wr_en;
   logic [7:0] fb_wr_addr;
   logic [7:0] fb_wr_data;
   logic       frame_done;
   logic       frame_err;

   int         vectors     = 0;
   int         miscompares = 0;

   logic [7:0] wr_addr_q[$];
   logic [7:0] wr_data_q[$];
   int         done_cnt  = 0;
   logic [7:0] done_addr = 8'd0;

   lcd_rx #(
      .IDLE_CYCLES(64),
      .FRAME_BYTES(256)
   ) dut (
      .fpga_clk   (fpga_clk),
      .rst_in     (rst_in),
      .lcd_clk    (lcd_clk),
      .lcd_data   (lcd_data),
      .fb_wr_en   (fb_wr_en),
      .fb_wr_addr (fb_wr_addr),
      .fb_wr_data (fb_wr_data),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   // 100 MHz system clock.
   always #5 fpga_clk = ~fpga_clk;

   // Monitor: samples on the falling edge, away from where the DUT updates,
   // and logs every write and every frame_done pulse.
   initial begin
      forever begin
         @(negedge fpga_clk);
         if (fb_wr_en === 1'b1) begin
            wr_addr_q.push_back(fb_wr_addr);
            wr_data_q.push_back(fb_wr_data);
         end
         if (frame_done === 1'b1) begin
            done_cnt++;
            done_addr = fb_wr_addr;
         end
      end
   end

   // Safety net so the run always ends even if something stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [7:0] logged_addr(input int idx);
      if (idx < wr_addr_q.size()) return wr_addr_q[idx];
      return 8'hxx;
   endfunction

   function automatic logic [7:0] logged_data(input int idx);
      if (idx < wr_data_q.size()) return wr_data_q[idx];
      return 8'hxx;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge fpga_clk);
   endtask

   // One serial bit: 4 cycles low with data set up, then 4 cycles high.
   task automatic send_bit(input logic b);
      lcd_data = b;
      wait_cycles(4);
      lcd_clk = 1'b1;
      wait_cycles(4);
      lcd_clk = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] value);
      for (int i = 7; i >= 0; i--) begin
         send_bit(value[i]);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checkOutput({tag, "_wr_en"},   32'(fb_wr_en),   32'h0);
      checkOutput({tag, "_addr"},    32'(fb_wr_addr), 32'h0);
      checkOutput({tag, "_data"},    32'(fb_wr_data), 32'h0);
      checkOutput({tag, "_done"},    32'(frame_done), 32'h0);
      checkOutput({tag, "_err"},     32'(frame_err),  32'h0);
   endtask

   task automatic do_reset();
      @(negedge fpga_clk);
      rst_in   = 1'b0;
      lcd_clk  = 1'b0;
      lcd_data = 1'b0;
      wait_cycles(3);
      rst_in = 1'b1;
      wait_cycles(2);
   endtask

   initial begin
      int base;
      int done_base;

      $display("[TB] lcd_rx directed test start");

      // Reset values.
      rst_in = 1'b0;
      wait_cycles(3);
      check_reset_outputs("por");
      rst_in = 1'b1;
      wait_cycles(2);

      // Single byte 0xA5.
      base = wr_addr_q.size();
      applyStimulus(8'hA5);
      wait_cycles(8);
      checkOutput("a5_count", 32'(wr_addr_q.size() - base), 32'd1);
      checkOutput("a5_addr",  32'(logged_addr(base)), 32'h00);
      checkOutput("a5_data",  32'(logged_data(base)), 32'hA5);
      checkOutput("a5_err",   32'(frame_err), 32'h0);
      wait_cycles(20);
      checkOutput("hold_en",   32'(fb_wr_en),   32'h0);
      checkOutput("hold_data", 32'(fb_wr_data), 32'hA5);
      checkOutput("hold_addr", 32'(fb_wr_addr), 32'h00);

      // Full frame 0x00..0xFF, then one more byte to show the index wrapped.
      do_reset();
      base      = wr_addr_q.size();
      done_base = done_cnt;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(8'(i));
      end
      wait_cycles(8);
      checkOutput("frame_count", 32'(wr_addr_q.size() - base), 32'd256);
      for (int i = 0; i < 256; i++) begin
         checkOutput("frame_addr", 32'(logged_addr(base + i)), 32'(i));
         checkOutput("frame_data", 32'(logged_data(base + i)), 32'(i));
      end
      checkOutput("frame_done_cnt",  32'(done_cnt - done_base), 32'd1);
      checkOutput("frame_done_addr", 32'(done_addr), 32'hFF);
      checkOutput("frame_err",       32'(frame_err), 32'h0);
      applyStimulus(8'h55);
      wait_cycles(8);
      checkOutput("wrap_addr", 32'(logged_addr(base + 256)), 32'h00);
      checkOutput("wrap_data", 32'(logged_data(base + 256)), 32'h55);

      // Three bits then exactly 64 low cycles: gap mid-byte sets the error.
      do_reset();
      base = wr_addr_q.size();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      wait_cycles(60);
      checkOutput("short_no_strobe", 32'(wr_addr_q.size() - base), 32'd0);
      applyStimulus(8'h3C);
      wait_cycles(8);
      checkOutput("short_err",   32'(frame_err), 32'h1);
      checkOutput("short_count", 32'(wr_addr_q.size() - base), 32'd1);
      checkOutput("short_addr",  32'(logged_addr(base)), 32'h00);
      checkOutput("short_data",  32'(logged_data(base)), 32'h3C);

      // Full frame, 64-cycle gap, second frame of 0xFF, then a final gap.
      do_reset();
      base      = wr_addr_q.size();
      done_base = done_cnt;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(8'(i));
      end
      wait_cycles(60);
      for (int i = 0; i < 256; i++) begin
         applyStimulus(8'hFF);
      end
      wait_cycles(8);
      checkOutput("two_count",      32'(wr_addr_q.size() - base), 32'd512);
      checkOutput("two_first_addr", 32'(logged_addr(base + 256)), 32'h00);
      checkOutput("two_first_data", 32'(logged_data(base + 256)), 32'hFF);
      checkOutput("two_last_addr",  32'(logged_addr(base + 511)), 32'hFF);
      checkOutput("two_done_cnt",   32'(done_cnt - done_base), 32'd2);
      checkOutput("two_err",        32'(frame_err), 32'h0);
      wait_cycles(70);
      checkOutput("two_gap_err",    32'(frame_err), 32'h0);

      // Reset after 10 bytes and 5 bits discards the partial data.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(8'(8'h10 + i));
      end
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      checkOutput("mid_pre_addr", 32'(fb_wr_addr), 32'h09);
      checkOutput("mid_pre_data", 32'(fb_wr_data), 32'h19);
      rst_in = 1'b0;
      wait_cycles(2);
      check_reset_outputs("mid_rst");
      rst_in = 1'b1;
      wait_cycles(2);
      base = wr_addr_q.size();
      applyStimulus(8'h81);
      wait_cycles(8);
      checkOutput("mid_count", 32'(wr_addr_q.size() - base), 32'd1);
      checkOutput("mid_addr",  32'(logged_addr(base)), 32'h00);
      checkOutput("mid_data",  32'(logged_data(base)), 32'h81);
      checkOutput("mid_err",   32'(frame_err), 32'h0);

      // Exactly 63 low cycles between bytes is not a gap.
      do_reset();
      base = wr_addr_q.size();
      applyStimulus(8'h11);
      wait_cycles(59);
      applyStimulus(8'h22);
      wait_cycles(8);
      checkOutput("g63_count", 32'(wr_addr_q.size() - base), 32'd2);
      checkOutput("g63_addr",  32'(logged_addr(base + 1)), 32'h01);
      checkOutput("g63_data",  32'(logged_data(base + 1)), 32'h22);
      checkOutput("g63_err",   32'(frame_err), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
